// File: rtl/dac_spi_arbiter_if.sv
// Signal bundle between the two DAC requesters, the arbiter and the shared DAC SPI master.
// The slave modport is the arbiter's view; the master modport is the requesters' and SPI master's view.
interface dac_spi_arbiter_if #(
  parameter int unsigned DAC_WID = 24
);
  logic               req0_arm;
  logic               req1_arm;
  logic               req0_ss;
  logic               req1_ss;
  logic               req0_lock;
  logic               req1_lock;
  logic [DAC_WID-1:0] req0_to_dac;
  logic [DAC_WID-1:0] req1_to_dac;
  logic [DAC_WID-1:0] req0_from_dac;
  logic [DAC_WID-1:0] req1_from_dac;
  logic               req0_finished;
  logic               req1_finished;
  logic               req0_grant;
  logic               req1_grant;
  logic               dac_arm;
  logic               dac_ss;
  logic [DAC_WID-1:0] dac_to;
  logic [DAC_WID-1:0] dac_from;
  logic               dac_finished;

  modport slave (
    input  req0_arm, req1_arm, req0_ss, req1_ss, req0_lock, req1_lock,
    input  req0_to_dac, req1_to_dac, dac_from, dac_finished,
    output req0_from_dac, req1_from_dac, req0_finished, req1_finished,
    output req0_grant, req1_grant, dac_arm, dac_ss, dac_to
  );

  modport master (
    output req0_arm, req1_arm, req0_ss, req1_ss, req0_lock, req1_lock,
    output req0_to_dac, req1_to_dac, dac_from, dac_finished,
    input  req0_from_dac, req1_from_dac, req0_finished, req1_finished,
    input  req0_grant, req1_grant, dac_arm, dac_ss, dac_to
  );
endinterface

// File: rtl/dac_spi_arbiter.sv
// Two-requester arbiter for the shared DAC SPI master with per-requester ownership lock.
// Define DAC_SPI_ARBITER_ROUND_ROBIN_EN for round-robin ties; otherwise requester 0 wins ties.
module dac_spi_arbiter (
  input logic              clk,
  input logic              rst_L,
  dac_spi_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e state_q;
  logic   rr_last_q;
  logic   tie_to_0;

`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
  // rr_last_q == 1 means requester 1 owned last, so requester 0 gets the tie.
  assign tie_to_0 = rr_last_q;
`else
  logic unused_rr_last;
  assign unused_rr_last = rr_last_q;
  assign tie_to_0       = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q   <= StIdle;
      rr_last_q <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req0_arm && bus.req1_arm) begin
            state_q <= tie_to_0 ? StGrant0 : StGrant1;
          end else if (bus.req0_arm) begin
            state_q <= StGrant0;
          end else if (bus.req1_arm) begin
            state_q <= StGrant1;
          end
        end
        StGrant0: begin
          // A finished still high means the master has not returned to idle yet.
          if (!bus.req0_arm && !bus.req0_lock && !bus.dac_finished) begin
            state_q   <= StIdle;
            rr_last_q <= 1'b0;
          end
        end
        StGrant1: begin
          if (!bus.req1_arm && !bus.req1_lock && !bus.dac_finished) begin
            state_q   <= StIdle;
            rr_last_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.req0_grant    = (state_q == StGrant0);
    bus.req1_grant    = (state_q == StGrant1);
    bus.dac_arm       = 1'b0;
    bus.dac_ss        = 1'b0;
    bus.dac_to        = '0;
    bus.req0_finished = 1'b0;
    bus.req1_finished = 1'b0;
    bus.req0_from_dac = '0;
    bus.req1_from_dac = '0;
    case (state_q)
      StGrant0: begin
        bus.dac_arm       = bus.req0_arm;
        bus.dac_ss        = bus.req0_ss;
        bus.dac_to        = bus.req0_to_dac;
        bus.req0_finished = bus.dac_finished;
        bus.req0_from_dac = bus.dac_from;
      end
      StGrant1: begin
        bus.dac_arm       = bus.req1_arm;
        bus.dac_ss        = bus.req1_ss;
        bus.dac_to        = bus.req1_to_dac;
        bus.req1_finished = bus.dac_finished;
        bus.req1_from_dac = bus.dac_from;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Directed bench for dac_spi_arbiter; a monitor checks every finished pulse against a scoreboard.
module tb_dac_spi_arbiter;
  localparam int unsigned W = 24;

  logic clk   = 1'b0;
  logic rst_L = 1'b0;
  always #5 clk = ~clk;

  dac_spi_arbiter_if #(.DAC_WID(W)) bus ();

  dac_spi_arbiter dut (
    .clk   (clk),
    .rst_L (rst_L),
    .bus   (bus)
  );

  typedef struct packed {
    logic         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic exp_id;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic pop_check(input logic id, input logic [W-1:0] d);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_finished: got requester %0d data %h want none", id, d);
    end else begin
      e = exp_q.pop_front();
      check("finish_owner", {{(W-1){1'b0}}, id}, {{(W-1){1'b0}}, e.id});
      check("finish_data", d, e.data);
    end
  endtask

  // Monitor: each rising finished on either requester consumes one scoreboard entry.
  logic p0 = 1'b0;
  logic p1 = 1'b0;
  always @(negedge clk) begin
    if (bus.req0_finished && !p0) pop_check(1'b0, bus.req0_from_dac);
    if (bus.req1_finished && !p1) pop_check(1'b1, bus.req1_from_dac);
    p0 <= bus.req0_finished;
    p1 <= bus.req1_finished;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; leaves dac_finished low just after the next posedge.
  task automatic finish_txn(input logic id, input logic [W-1:0] d);
    exp_q.push_back('{id: id, data: d});
    bus.dac_from     = d;
    bus.dac_finished = 1'b1;
    cyc();
    bus.dac_finished = 1'b0;
  endtask

  task automatic check_idle(input string nm);
    check({nm, "_g0"}, {23'd0, bus.req0_grant}, 24'd0);
    check({nm, "_g1"}, {23'd0, bus.req1_grant}, 24'd0);
    check({nm, "_arm"}, {23'd0, bus.dac_arm}, 24'd0);
    check({nm, "_to"}, bus.dac_to, 24'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0_arm = 1'b1; bus.req0_ss = 1'b1; bus.req0_lock = 1'b0; bus.req0_to_dac = 24'hABCDEF;
    bus.req1_arm = 1'b0; bus.req1_ss = 1'b0; bus.req1_lock = 1'b0; bus.req1_to_dac = '0;
    bus.dac_from = 24'h777777; bus.dac_finished = 1'b1;

    // Reset: everything reads idle even with requests and master activity present.
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    check("reset_ss", {23'd0, bus.dac_ss}, 24'd0);
    check("reset_from0", bus.req0_from_dac, 24'd0);
    check("reset_fin0", {23'd0, bus.req0_finished}, 24'd0);
    bus.req0_arm = 1'b0; bus.req0_ss = 1'b0; bus.req0_to_dac = '0;
    bus.dac_finished = 1'b0; bus.dac_from = '0;
    rst_L = 1'b1;

    // Single request from requester 1.
    cyc();
    bus.req1_arm = 1'b1; bus.req1_ss = 1'b1; bus.req1_to_dac = 24'h1ABCDE;
    @(negedge clk);
    check("t1_pre_grant", {23'd0, bus.req1_grant}, 24'd0);
    check("t1_pre_arm", {23'd0, bus.dac_arm}, 24'd0);
    cyc();
    @(negedge clk);
    check("t1_grant1", {23'd0, bus.req1_grant}, 24'd1);
    check("t1_grant0", {23'd0, bus.req0_grant}, 24'd0);
    check("t1_arm", {23'd0, bus.dac_arm}, 24'd1);
    check("t1_ss", {23'd0, bus.dac_ss}, 24'd1);
    check("t1_to", bus.dac_to, 24'h1ABCDE);
    cyc();
    exp_q.push_back('{id: 1'b1, data: 24'h000123});
    bus.dac_from = 24'h000123; bus.dac_finished = 1'b1;
    @(negedge clk);
    check("t1_other_fin", {23'd0, bus.req0_finished}, 24'd0);
    check("t1_other_from", bus.req0_from_dac, 24'd0);
    cyc();
    bus.dac_finished = 1'b0; bus.req1_arm = 1'b0; bus.req1_ss = 1'b0;
    @(negedge clk);
    check("t1_hold", {23'd0, bus.req1_grant}, 24'd1);
    cyc();
    @(negedge clk);
    check_idle("t1_release");

    // Tie from reset, then a second tie after requester 0 has owned.
    bus.req0_arm = 1'b1; bus.req0_ss = 1'b1; bus.req0_to_dac = 24'h0A0A0A;
    bus.req1_arm = 1'b1; bus.req1_ss = 1'b1; bus.req1_to_dac = 24'h0B0B0B;
    cyc();
    @(negedge clk);
    check("tie1_g0", {23'd0, bus.req0_grant}, 24'd1);
    check("tie1_g1", {23'd0, bus.req1_grant}, 24'd0);
    check("tie1_to", bus.dac_to, 24'h0A0A0A);
    cyc();
    finish_txn(1'b0, 24'h111111);
    bus.req0_arm = 1'b0; bus.req1_arm = 1'b0;
    cyc();
    @(negedge clk);
    check_idle("tie1_release");
    bus.req0_arm = 1'b1; bus.req1_arm = 1'b1;
`ifdef DAC_SPI_ARBITER_ROUND_ROBIN_EN
    exp_id = 1'b1;
`else
    exp_id = 1'b0;
`endif
    cyc();
    @(negedge clk);
    check("tie2_g0", {23'd0, bus.req0_grant}, {23'd0, ~exp_id});
    check("tie2_g1", {23'd0, bus.req1_grant}, {23'd0, exp_id});
    check("tie2_to", bus.dac_to, exp_id ? 24'h0B0B0B : 24'h0A0A0A);
    cyc();
    finish_txn(exp_id, 24'h222222);
    bus.req0_arm = 1'b0; bus.req1_arm = 1'b0; bus.req0_ss = 1'b0; bus.req1_ss = 1'b0;
    cyc();
    @(negedge clk);
    check_idle("tie2_release");

    // Locked readback: requester 1 must wait through the gap between commands.
    bus.req0_arm = 1'b1; bus.req0_lock = 1'b1; bus.req0_ss = 1'b1; bus.req0_to_dac = 24'h900000;
    cyc();
    @(negedge clk);
    check("lock_g0", {23'd0, bus.req0_grant}, 24'd1);
    check("lock_to", bus.dac_to, 24'h900000);
    cyc();
    finish_txn(1'b0, 24'h9ABCDE);
    bus.req0_arm = 1'b0;
    bus.req1_arm = 1'b1; bus.req1_ss = 1'b1; bus.req1_to_dac = 24'h2D2D2D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lock_gap_g0", {23'd0, bus.req0_grant}, 24'd1);
      check("lock_gap_g1", {23'd0, bus.req1_grant}, 24'd0);
      check("lock_gap_arm", {23'd0, bus.dac_arm}, 24'd0);
      check("lock_gap_ss", {23'd0, bus.dac_ss}, 24'd1);
      cyc();
    end
    bus.req0_to_dac = 24'h000000; bus.req0_arm = 1'b1;
    @(negedge clk);
    check("lock_rearm_arm", {23'd0, bus.dac_arm}, 24'd1);
    check("lock_rearm_g0", {23'd0, bus.req0_grant}, 24'd1);
    check("lock_rearm_to", bus.dac_to, 24'h000000);
    cyc();
    finish_txn(1'b0, 24'h0FFFFF);
    bus.req0_arm = 1'b0; bus.req0_lock = 1'b0; bus.req0_ss = 1'b0;
    @(negedge clk);
    check("lock_drop_hold", {23'd0, bus.req0_grant}, 24'd1);
    cyc();
    @(negedge clk);
    check("lock_gap_idle0", {23'd0, bus.req0_grant}, 24'd0);
    check("lock_gap_idle1", {23'd0, bus.req1_grant}, 24'd0);
    cyc();
    @(negedge clk);
    check("lock_next_g1", {23'd0, bus.req1_grant}, 24'd1);
    check("lock_next_to", bus.dac_to, 24'h2D2D2D);
    cyc();
    finish_txn(1'b1, 24'h333333);
    bus.req1_arm = 1'b0; bus.req1_ss = 1'b0;
    cyc();
    @(negedge clk);
    check_idle("lock_end");

    // Release is held off while the master's finished stays high.
    bus.req0_arm = 1'b1; bus.req0_ss = 1'b1; bus.req0_to_dac = 24'h444000;
    cyc();
    exp_q.push_back('{id: 1'b0, data: 24'h444444});
    bus.dac_from = 24'h444444; bus.dac_finished = 1'b1;
    bus.req0_arm = 1'b0; bus.req0_ss = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fin_hold_g0", {23'd0, bus.req0_grant}, 24'd1);
      cyc();
    end
    bus.dac_finished = 1'b0;
    @(negedge clk);
    check("fin_fall_g0", {23'd0, bus.req0_grant}, 24'd1);
    cyc();
    @(negedge clk);
    check_idle("fin_release");

    // Asynchronous reset in the middle of a requester 1 transaction.
    bus.req1_arm = 1'b1; bus.req1_ss = 1'b1; bus.req1_to_dac = 24'h555555;
    cyc();
    #2;
    check("rst_pre_arm", {23'd0, bus.dac_arm}, 24'd1);
    rst_L = 1'b0;
    #1;
    check_idle("rst_async");
    check("rst_async_ss", {23'd0, bus.dac_ss}, 24'd0);
    bus.req1_arm = 1'b0; bus.req1_ss = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    bus.req0_arm = 1'b1; bus.req0_ss = 1'b1; bus.req0_to_dac = 24'h666000;
    bus.req1_arm = 1'b1; bus.req1_ss = 1'b1; bus.req1_to_dac = 24'h6A6A6A;
    cyc();
    @(negedge clk);
    check("rst_tie_g0", {23'd0, bus.req0_grant}, 24'd1);
    check("rst_tie_g1", {23'd0, bus.req1_grant}, 24'd0);
    cyc();
    finish_txn(1'b0, 24'h666666);
    bus.req0_arm = 1'b0; bus.req1_arm = 1'b0; bus.req0_ss = 1'b0; bus.req1_ss = 1'b0;
    cyc();
    @(negedge clk);
    check_idle("rst_tie_release");

    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
